// File: rtl/isp_bayer_pkg.sv
// Bayer pattern constants, channel select and colour-bar palette shared by the
// re-mosaic and demosaic stages.
package isp_bayer_pkg;

  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } bayer_ch_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // pat[0] flips the column phase, pat[1] flips the row phase.
  function automatic bayer_ch_e bayer_ch(input logic x0, input logic y0,
                                         input logic [1:0] pat);
    logic cx, ry;
    cx = x0 ^ pat[0];
    ry = y0 ^ pat[1];
    if (!cx && !ry)     return CH_R;
    else if (cx && ry)  return CH_B;
    else                return CH_G;
  endfunction

  // White, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t colorbar_rgb(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb2raw_colorbar.sv
// Eight-bar colour generator; bar width is H_ACTIVE/8 with the last bar
// absorbing the remainder. Built only when RGB2RAW_COLORBAR_EN is defined.
module rgb2raw_colorbar
  import isp_bayer_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       advance,
  input  logic       line_end,
  input  logic       Frame_Sync,
  output logic [7:0] bar_r,
  output logic [7:0] bar_g,
  output logic [7:0] bar_b
);

  // Narrow test lines (< 8 pixels) still step one bar per pixel.
  localparam int               BW      = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BW - 1);

  logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_e;
  logic [2:0]       bar_q, bar_d, bar_e;
  rgb_t             col;

  // A Frame_Sync pixel is the first pixel of a line, so it sees bar 0.
  assign wcnt_e = Frame_Sync ? '0 : wcnt_q;
  assign bar_e  = Frame_Sync ? '0 : bar_q;

  assign col   = colorbar_rgb(bar_e);
  assign bar_r = col.r;
  assign bar_g = col.g;
  assign bar_b = col.b;

  always_comb begin
    wcnt_d = wcnt_q;
    bar_d  = bar_q;
    if (advance) begin
      if (line_end) begin
        wcnt_d = '0;
        bar_d  = '0;
      end else if (wcnt_e == BW_LAST) begin
        wcnt_d = '0;
        bar_d  = (bar_e == 3'd7) ? 3'd7 : bar_e + 3'd1;
      end else begin
        wcnt_d = wcnt_e + 1'b1;
        bar_d  = bar_e;
      end
    end else if (Frame_Sync) begin
      wcnt_d = '0;
      bar_d  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wcnt_q <= '0;
      bar_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      bar_q  <= bar_d;
    end
  end

endmodule

// File: rtl/rgb2raw_mosaic.sv
// Demand-driven RGB -> 8-bit Bayer RAW re-mosaic with 1-cycle latency.
// Define RGB2RAW_COLORBAR_EN to replace the RGB inputs with internal colour bars.
module rgb2raw_mosaic
  import isp_bayer_pkg::*;
#(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter logic [1:0] BAYER_PAT = BAYER_RGGB
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Frame_Sync,
  input  logic       DoutReq,
  output logic       DinReq,
  input  logic [7:0] RED,
  input  logic [7:0] GREEN,
  input  logic [7:0] BLUE,
  output logic [7:0] RAW_Data,
  output logic       RAW_Valid,
  output logic       Xaddr,
  output logic       Yaddr,
  output logic       Line_End,
  output logic       Frame_End
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] x_e, y_e;
  logic             line_last, frame_last;
  logic [7:0]       data_q, data_d;
  logic             valid_q, xaddr_q, xaddr_d, yaddr_q, yaddr_d;
  logic             le_q, le_d, fe_q, fe_d;
  logic [7:0]       pix_r, pix_g, pix_b;

  assign DinReq = DoutReq;

  // Frame_Sync relabels the pixel accepted on the same edge as (0,0).
  assign x_e        = Frame_Sync ? '0 : x_q;
  assign y_e        = Frame_Sync ? '0 : y_q;
  assign line_last  = (x_e == X_LAST);
  assign frame_last = line_last && (y_e == Y_LAST);

`ifdef RGB2RAW_COLORBAR_EN
  logic unused_rgb;
  assign unused_rgb = ^{RED, GREEN, BLUE};

  rgb2raw_colorbar #(
    .H_ACTIVE (H_ACTIVE)
  ) u_colorbar (
    .Clk        (Clk),
    .Rst        (Rst),
    .advance    (DoutReq),
    .line_end   (line_last),
    .Frame_Sync (Frame_Sync),
    .bar_r      (pix_r),
    .bar_g      (pix_g),
    .bar_b      (pix_b)
  );
`else
  assign pix_r = RED;
  assign pix_g = GREEN;
  assign pix_b = BLUE;
`endif

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    xaddr_d = xaddr_q;
    yaddr_d = yaddr_q;
    le_d    = 1'b0;
    fe_d    = 1'b0;
    if (DoutReq) begin
      case (bayer_ch(x_e[0], y_e[0], BAYER_PAT))
        CH_R:    data_d = pix_r;
        CH_B:    data_d = pix_b;
        default: data_d = pix_g;
      endcase
      xaddr_d = x_e[0];
      yaddr_d = y_e[0];
      le_d    = line_last;
      fe_d    = frame_last;
      if (line_last) begin
        x_d = '0;
        y_d = (y_e == Y_LAST) ? '0 : y_e + 1'b1;
      end else begin
        x_d = x_e + 1'b1;
        y_d = y_e;
      end
    end else if (Frame_Sync) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      xaddr_q <= 1'b0;
      yaddr_q <= 1'b0;
      le_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= DoutReq;
      xaddr_q <= xaddr_d;
      yaddr_q <= yaddr_d;
      le_q    <= le_d;
      fe_q    <= fe_d;
    end
  end

  assign RAW_Data  = data_q;
  assign RAW_Valid = valid_q;
  assign Xaddr     = xaddr_q;
  assign Yaddr     = yaddr_q;
  assign Line_End  = le_q;
  assign Frame_End = fe_q;

endmodule

// File: tb/tb_rgb2raw_mosaic.sv
// Bench for rgb2raw_mosaic: two instances (RGGB and BGGR) on a 4x2 frame share
// one stimulus stream and are checked against a pixel-index reference model.
module tb_rgb2raw_mosaic;

  localparam int H = 4;
  localparam int V = 2;

  logic       Clk = 1'b0;
  logic       Rst, Frame_Sync, DoutReq;
  logic [7:0] RED, GREEN, BLUE;
  logic       din0, din3;
  logic [7:0] raw0, raw3;
  logic       v0, v3, xa0, xa3, ya0, ya3, le0, le3, fe0, fe3;

  always #5 Clk = ~Clk;

  rgb2raw_mosaic #(.H_ACTIVE(H), .V_ACTIVE(V), .BAYER_PAT(2'd0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Frame_Sync(Frame_Sync), .DoutReq(DoutReq), .DinReq(din0),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .RAW_Data(raw0), .RAW_Valid(v0),
    .Xaddr(xa0), .Yaddr(ya0), .Line_End(le0), .Frame_End(fe0));

  rgb2raw_mosaic #(.H_ACTIVE(H), .V_ACTIVE(V), .BAYER_PAT(2'd3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Frame_Sync(Frame_Sync), .DoutReq(DoutReq), .DinReq(din3),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .RAW_Data(raw3), .RAW_Valid(v3),
    .Xaddr(xa3), .Yaddr(ya3), .Line_End(le3), .Frame_End(fe3));

  int total = 0;
  int bad   = 0;

  // Model state: linear pixel index within the frame, plus expected outputs.
  int         mp = 0;
  logic [7:0] e_d0 = '0, e_d3 = '0;
  logic [4:0] e_fl = '0;  // {valid, xaddr, yaddr, line_end, frame_end}

  function automatic logic [7:0] ref_sel(int pat, int x, int y, logic [23:0] rgb);
    int cx, ry;
    cx = (x % 2) ^ (pat % 2);
    ry = (y % 2) ^ (pat / 2);
    if (cx == 0 && ry == 0) return rgb[23:16];
    if (cx == 1 && ry == 1) return rgb[7:0];
    return rgb[15:8];
  endfunction

  function automatic logic [23:0] ref_rgb(int x, logic [7:0] r, logic [7:0] g, logic [7:0] b);
`ifdef RGB2RAW_COLORBAR_EN
    int bw, bar;
    logic [23:0] pal [8];
    pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bw  = (H / 8 < 1) ? 1 : H / 8;
    bar = x / bw;
    if (bar > 7) bar = 7;
    return pal[bar];
`else
    return {r, g, b};
`endif
  endfunction

  task automatic cycle(input logic rst, input logic fs, input logic req,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int pos, x, y;
    logic [23:0] rgb;
    Rst = rst; Frame_Sync = fs; DoutReq = req; RED = r; GREEN = g; BLUE = b;
    @(posedge Clk);
    if (rst) begin
      mp = 0; e_fl = '0; e_d0 = '0; e_d3 = '0;
    end else if (req) begin
      pos  = fs ? 0 : mp;
      x    = pos % H;
      y    = pos / H;
      rgb  = ref_rgb(x, r, g, b);
      e_d0 = ref_sel(0, x, y, rgb);
      e_d3 = ref_sel(3, x, y, rgb);
      e_fl = {1'b1, 1'(x % 2), 1'(y % 2), x == H - 1, pos == H * V - 1};
      mp   = (pos + 1) % (H * V);
    end else begin
      e_fl = {1'b0, e_fl[3:2], 2'b00};
      if (fs) mp = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 8'hAA, 8'hBB, 8'hCC);
    cycle(1, 1, 1, 8'h12, 8'h34, 8'h56);
    if ({raw0, v0, xa0, ya0, le0, fe0} !== 13'h0) begin
      bad++; $display("FAIL reset_pat0 got=%h exp=0", {raw0, v0, xa0, ya0, le0, fe0});
    end
    total++;
    if ({raw3, v3, xa3, ya3, le3, fe3} !== 13'h0) begin
      bad++; $display("FAIL reset_pat3 got=%h exp=0", {raw3, v3, xa3, ya3, le3, fe3});
    end
    total++;
  endtask

  task automatic test_stream();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * H * V + 1; i++) begin
      cycle(0, 0, 1, 8'h11, 8'h22, 8'h33);
      if ({raw0, v0, xa0, ya0, le0, fe0} !== {e_d0, e_fl}) begin
        bad++; $display("FAIL stream_const_pat0 i=%0d got=%h exp=%h", i, {raw0, v0, xa0, ya0, le0, fe0}, {e_d0, e_fl});
      end
      total++;
      if ({raw3, v3, xa3, ya3, le3, fe3} !== {e_d3, e_fl}) begin
        bad++; $display("FAIL stream_const_pat3 i=%0d got=%h exp=%h", i, {raw3, v3, xa3, ya3, le3, fe3}, {e_d3, e_fl});
      end
      total++;
    end
    for (int i = 0; i < 3 * H * V; i++) begin
      cycle(0, 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      if ({raw0, v0, xa0, ya0, le0, fe0} !== {e_d0, e_fl}) begin
        bad++; $display("FAIL stream_rand_pat0 i=%0d got=%h exp=%h", i, {raw0, v0, xa0, ya0, le0, fe0}, {e_d0, e_fl});
      end
      total++;
      if ({raw3, v3, xa3, ya3, le3, fe3} !== {e_d3, e_fl}) begin
        bad++; $display("FAIL stream_rand_pat3 i=%0d got=%h exp=%h", i, {raw3, v3, xa3, ya3, le3, fe3}, {e_d3, e_fl});
      end
      total++;
    end
  endtask

  task automatic test_stall();
    logic pat [4];
    logic req;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      req = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
      Rst = 0; DoutReq = req; #1;
      if ({din0, din3} !== {req, req}) begin
        bad++; $display("FAIL stall_dinreq i=%0d got=%b%b exp=%b", i, din0, din3, req);
      end
      total++;
      cycle(0, 0, req, 8'($urandom), 8'($urandom), 8'($urandom));
      if ({raw0, v0, xa0, ya0, le0, fe0} !== {e_d0, e_fl}) begin
        bad++; $display("FAIL stall_pat0 i=%0d got=%h exp=%h", i, {raw0, v0, xa0, ya0, le0, fe0}, {e_d0, e_fl});
      end
      total++;
      if ({raw3, v3, xa3, ya3, le3, fe3} !== {e_d3, e_fl}) begin
        bad++; $display("FAIL stall_pat3 i=%0d got=%h exp=%h", i, {raw3, v3, xa3, ya3, le3, fe3}, {e_d3, e_fl});
      end
      total++;
    end
  endtask

  task automatic test_frame_sync();
    logic fs, req;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'($urandom), 8'($urandom), 8'($urandom));
    cycle(0, 1, 1, 8'h5A, 8'h6B, 8'h7C);
    if ({xa0, ya0, v0, fe0} !== 4'b0010) begin
      bad++; $display("FAIL fsync_pos got=%b exp=0010", {xa0, ya0, v0, fe0});
    end
    total++;
    if (raw0 !== e_d0) begin
      bad++; $display("FAIL fsync_data got=%h exp=%h", raw0, e_d0);
    end
    total++;
    for (int i = 0; i < 60; i++) begin
      fs  = ($urandom_range(0, 7) == 0);
      req = ($urandom_range(0, 3) != 0);
      cycle(0, fs, req, 8'($urandom), 8'($urandom), 8'($urandom));
      if ({raw0, v0, xa0, ya0, le0, fe0} !== {e_d0, e_fl}) begin
        bad++; $display("FAIL fsync_pat0 i=%0d got=%h exp=%h", i, {raw0, v0, xa0, ya0, le0, fe0}, {e_d0, e_fl});
      end
      total++;
      if ({raw3, v3, xa3, ya3, le3, fe3} !== {e_d3, e_fl}) begin
        bad++; $display("FAIL fsync_pat3 i=%0d got=%h exp=%h", i, {raw3, v3, xa3, ya3, le3, fe3}, {e_d3, e_fl});
      end
      total++;
    end
  endtask

  task automatic test_reset_midline();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 8'h01, 8'h02, 8'h03);
    cycle(0, 0, 1, 8'h04, 8'h05, 8'h06);
    cycle(1, 0, 1, 8'h07, 8'h08, 8'h09);
    if ({raw0, v0, xa0, ya0, le0, fe0, raw3, v3} !== 22'h0) begin
      bad++; $display("FAIL rst_mid got=%h exp=0", {raw0, v0, xa0, ya0, le0, fe0, raw3, v3});
    end
    total++;
    cycle(0, 0, 1, 8'hA1, 8'hA2, 8'hA3);
    if ({raw0, v0, xa0, ya0, le0, fe0} !== {e_d0, e_fl} || {xa0, ya0} !== 2'b00) begin
      bad++; $display("FAIL rst_first_pat0 got=%h exp=%h", {raw0, v0, xa0, ya0, le0, fe0}, {e_d0, e_fl});
    end
    total++;
    if ({raw3, v3, xa3, ya3, le3, fe3} !== {e_d3, e_fl}) begin
      bad++; $display("FAIL rst_first_pat3 got=%h exp=%h", {raw3, v3, xa3, ya3, le3, fe3}, {e_d3, e_fl});
    end
    total++;
  endtask

  initial begin
    Rst = 1; Frame_Sync = 0; DoutReq = 0; RED = 0; GREEN = 0; BLUE = 0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_frame_sync();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
